// File: rtl/i2c_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared encodings for the I2C access arbiter: request ops,
//                controller states and the requester count.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        OP_WR     = 2'b00,
        OP_RD     = 2'b01,
        OP_REG_RD = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RESP      = 3'd5
    } state_e;

    // True when the master transaction for this op/phase is a read.
    function automatic logic is_read_phase(input op_e op, input logic phase);
        return (op == OP_RD) || ((op == OP_REG_RD) && phase);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_access_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-input round-robin grant. The last-served requester has
//                the lowest priority; until anyone has been served, requester
//                0 wins a tie. Grant is one-hot and purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import i2c_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             upd,
    input  logic             upd_idx,
    output logic [N_REQ-1:0] gnt
);

    logic last_q, last_d;
    logic served_q, served_d;

    // Record the requester that was just served.
    always_comb begin
        last_d   = last_q;
        served_d = served_q;
        if (upd) begin
            last_d   = upd_idx;
            served_d = 1'b1;
        end
    end

    // Pointer register; starts at requester 0 with no history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b0;
            served_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            served_q <= served_d;
        end
    end

    // Tie goes to requester 1 only if requester 0 was served last.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (served_q && !last_q) ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_access_arbiter
//  Description : Shares a single-byte I2C master between two requesters.
//                Round-robin grant, one or two master transactions per
//                request, read-data capture and a per-phase watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_access_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [7*N_REQ-1:0] req_dev,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   resp_done,
    output logic [N_REQ-1:0]   resp_err,
    output logic [7:0]         resp_rdata,
    output logic [6:0]         m_addr,
    output logic [7:0]         m_data_in,
    output logic               m_rw,
    output logic               m_enable,
    input  logic               m_ready,
    input  logic [7:0]         m_data_out
);

    localparam logic [TO_W-1:0] c_wd_limit = TO_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic             gsel_q, gsel_d;
    op_e              op_q, op_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             phase_q, phase_d;
    logic             err_q, err_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic             m_enable_q, m_enable_d;
    logic             m_rw_q, m_rw_d;
    logic [6:0]       m_addr_q, m_addr_d;
    logic [7:0]       m_data_in_q, m_data_in_d;
    logic [N_REQ-1:0] resp_done_q, resp_done_d;
    logic [N_REQ-1:0] resp_err_q, resp_err_d;
    logic [7:0]       resp_rdata_q, resp_rdata_d;

    logic [N_REQ-1:0] w_req_mask;
    logic [N_REQ-1:0] w_gnt;
    logic             w_any_gnt;
    logic             w_sel_idx;
    op_e              w_sel_op;
    logic [6:0]       w_sel_dev;
    logic [7:0]       w_sel_wdata;
    logic             w_sel_rd;
    logic             w_arb_upd;
    logic             w_wd_hit;

    // A requester whose done pulse is on the wire this cycle has not yet had
    // a chance to drop req_valid, so it must not re-enter arbitration.
    assign w_req_mask = req_valid & ~resp_done_q;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req_mask),
        .upd     (w_arb_upd),
        .upd_idx (gsel_q),
        .gnt     (w_gnt)
    );

    assign w_any_gnt   = |w_gnt;
    assign w_sel_idx   = w_gnt[1];
    assign w_sel_op    = op_e'(w_sel_idx ? req_op[3:2] : req_op[1:0]);
    assign w_sel_dev   = w_sel_idx ? req_dev[13:7]   : req_dev[6:0];
    assign w_sel_wdata = w_sel_idx ? req_wdata[15:8] : req_wdata[7:0];
    assign w_sel_rd    = is_read_phase(w_sel_op, 1'b0);
    assign w_wd_hit    = (wd_q >= c_wd_limit);

    // Next-state, master handshake and response generation.
    always_comb begin
        state_d      = state_q;
        gsel_d       = gsel_q;
        op_d         = op_q;
        dev_d        = dev_q;
        wdata_d      = wdata_q;
        phase_d      = phase_q;
        err_d        = err_q;
        wd_d         = wd_q;
        m_enable_d   = m_enable_q;
        m_rw_d       = m_rw_q;
        m_addr_d     = m_addr_q;
        m_data_in_d  = m_data_in_q;
        resp_done_d  = '0;
        resp_err_d   = '0;
        resp_rdata_d = resp_rdata_q;
        w_arb_upd    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((|w_req_mask) && m_ready) begin
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (w_any_gnt) begin
                    gsel_d  = w_sel_idx;
                    op_d    = w_sel_op;
                    dev_d   = w_sel_dev;
                    wdata_d = w_sel_wdata;
                    phase_d = 1'b0;
                    err_d   = 1'b0;
                    if (w_sel_op == OP_RSVD) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        // Enable rises on entry to ISSUE: two cycles after the request.
                        state_d     = ST_ISSUE;
                        m_enable_d  = 1'b1;
                        m_addr_d    = w_sel_dev;
                        m_rw_d      = w_sel_rd;
                        m_data_in_d = w_sel_rd ? 8'h00 : w_sel_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                wd_d    = '0;
            end

            ST_WAIT_BUSY: begin
                if (!m_ready) begin
                    // Drop enable now so the master ends with STOP.
                    m_enable_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                    wd_d       = '0;
                end else if (w_wd_hit) begin
                    // Master never went busy; ready is already high, so respond.
                    m_enable_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (w_wd_hit) begin
                    m_enable_d = 1'b0;
                    err_d      = 1'b1;
                end
                if (m_ready) begin
                    if (err_q || w_wd_hit) begin
                        state_d = ST_RESP;
                    end else if ((op_q == OP_REG_RD) && !phase_q) begin
                        phase_d     = 1'b1;
                        state_d     = ST_ISSUE;
                        m_enable_d  = 1'b1;
                        m_rw_d      = 1'b1;
                        m_data_in_d = 8'h00;
                    end else begin
                        if (is_read_phase(op_q, phase_q)) begin
                            resp_rdata_d = m_data_out;
                        end
                        state_d = ST_RESP;
                    end
                end else if (!w_wd_hit) begin
                    wd_d = wd_q + TO_W'(1);
                end
            end

            ST_RESP: begin
                resp_done_d = gsel_q ? 2'b10 : 2'b01;
                resp_err_d  = err_q ? (gsel_q ? 2'b10 : 2'b01) : 2'b00;
                w_arb_upd   = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gsel_q       <= 1'b0;
            op_q         <= OP_WR;
            dev_q        <= '0;
            wdata_q      <= '0;
            phase_q      <= 1'b0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            m_enable_q   <= 1'b0;
            m_rw_q       <= 1'b0;
            m_addr_q     <= '0;
            m_data_in_q  <= '0;
            resp_done_q  <= '0;
            resp_err_q   <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gsel_q       <= gsel_d;
            op_q         <= op_d;
            dev_q        <= dev_d;
            wdata_q      <= wdata_d;
            phase_q      <= phase_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            m_enable_q   <= m_enable_d;
            m_rw_q       <= m_rw_d;
            m_addr_q     <= m_addr_d;
            m_data_in_q  <= m_data_in_d;
            resp_done_q  <= resp_done_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_done  = resp_done_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign m_addr     = m_addr_q;
    assign m_data_in  = m_data_in_q;
    assign m_rw       = m_rw_q;
    assign m_enable   = m_enable_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_access_arbiter
//  Description : Directed self-checking bench for i2c_access_arbiter with a
//                behavioural I2C master and a slave at 0x1D (reg 0x0F = 0x3C).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_access_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [13:0] req_dev;
    logic [15:0] req_wdata;
    logic [1:0]  resp_done;
    logic [1:0]  resp_err;
    logic [7:0]  resp_rdata;
    logic [6:0]  m_addr;
    logic [7:0]  m_data_in;
    logic        m_rw;
    logic        m_enable;
    logic        m_ready;
    logic [7:0]  m_data_out;

    i2c_access_arbiter #(
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_dev    (req_dev),
        .req_wdata  (req_wdata),
        .resp_done  (resp_done),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_ready    (m_ready),
        .m_data_out (m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural master + slave ----------------
    logic [6:0] t_addr[32];
    logic       t_rw[32];
    logic [7:0] t_data[32];
    int         t_ovl[32];
    int         t_n = 0;
    int         busy_cnt = 0;
    int         ovl = 0;
    int         en_rises = 0;
    logic       en_prev = 1'b0;
    logic       stuck = 1'b0;
    logic [7:0] ptr = 8'h00;

    initial begin
        m_ready    = 1'b1;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (m_enable && !en_prev) en_rises++;
            en_prev = m_enable;
            if (rst) begin
                m_ready  = 1'b1;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                if (m_enable) ovl++;
                if (!stuck) busy_cnt--;
                if (busy_cnt == 0) begin
                    m_ready = 1'b1;
                    if (t_n > 0) t_ovl[t_n-1] = ovl;
                end
            end else if (m_enable && m_ready && (t_n < 32)) begin
                t_addr[t_n] = m_addr;
                t_rw[t_n]   = m_rw;
                t_data[t_n] = m_data_in;
                t_ovl[t_n]  = 0;
                t_n++;
                if (m_rw)
                    m_data_out = (m_addr == 7'h1D) ? ((ptr == 8'h0F) ? 8'h3C : 8'h00) : 8'hFF;
                else if (m_addr == 7'h1D)
                    ptr = m_data_in;
                m_ready  = 1'b0;
                busy_cnt = 4;
                ovl      = 0;
            end
        end
    end

    int resp_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (resp_done != 2'b00) resp_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [1:0] op, input logic [6:0] dev, input logic [7:0] wd);
        if (i == 0) begin
            req_op[1:0]    = op;
            req_dev[6:0]   = dev;
            req_wdata[7:0] = wd;
        end else begin
            req_op[3:2]     = op;
            req_dev[13:7]   = dev;
            req_wdata[15:8] = wd;
        end
    endtask

    task automatic wait_resp(input string tag, output logic [1:0] d, output logic [1:0] e, output logic [7:0] r);
        logic seen;
        seen = 1'b0;
        d = 2'b00; e = 2'b00; r = 8'h00;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (resp_done != 2'b00) begin
                d = resp_done; e = resp_err; r = resp_rdata;
                req_valid = req_valid & ~resp_done;
                seen = 1'b1;
                break;
            end
        end
        chk_eq({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [1:0] d, e;
    logic [7:0] r;
    int base, rc0, en0;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_op = '0; req_dev = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk_eq("reset_state", {resp_done, resp_err, resp_rdata, m_addr, m_data_in, m_rw, m_enable}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Byte write, including the 2-cycle request-to-enable latency
        set_req(0, 2'b00, 7'h48, 8'hA5);
        req_valid[0] = 1'b1;
        @(negedge clk); chk_eq("lat_cyc1_en", m_enable, 1'b0);
        @(negedge clk); chk_eq("lat_cyc2_en", m_enable, 1'b1);
        wait_resp("wr", d, e, r);
        chk_eq("wr_done", d, 2'b01);
        chk_eq("wr_err", e, 2'b00);
        chk_eq("wr_ntxn", t_n, 1);
        chk_eq("wr_addr", t_addr[0], 7'h48);
        chk_eq("wr_rw", t_rw[0], 1'b0);
        chk_eq("wr_data", t_data[0], 8'hA5);

        // Register read: pointer write then read
        base = t_n;
        set_req(0, 2'b10, 7'h1D, 8'h0F);
        req_valid[0] = 1'b1;
        wait_resp("rr", d, e, r);
        chk_eq("rr_done", d, 2'b01);
        chk_eq("rr_err", e, 2'b00);
        chk_eq("rr_rdata", r, 8'h3C);
        chk_eq("rr_ntxn", t_n - base, 2);
        chk_eq("rr_p0_rw", t_rw[base], 1'b0);
        chk_eq("rr_p0_data", t_data[base], 8'h0F);
        chk_eq("rr_p1_rw", t_rw[base+1], 1'b1);
        chk_eq("rr_p1_addr", t_addr[base+1], 7'h1D);
        chk_eq("rr_p1_data", t_data[base+1], 8'h00);
        chk_eq("rr_p0_en_overlap", t_ovl[base], 1);
        chk_eq("rr_p1_en_overlap", t_ovl[base+1], 1);

        // Reserved op on requester 1: error, master untouched
        en0 = en_rises;
        set_req(1, 2'b11, 7'h22, 8'h00);
        req_valid[1] = 1'b1;
        wait_resp("rsvd", d, e, r);
        chk_eq("rsvd_done", d, 2'b10);
        chk_eq("rsvd_err", e, 2'b10);
        chk_eq("rsvd_rdata_kept", r, 8'h3C);
        @(negedge clk);
        chk_eq("rsvd_no_enable", en_rises, en0);

        // Timeout: master stays busy well beyond 16 cycles
        stuck = 1'b1;
        rc0 = resp_cnt;
        set_req(0, 2'b01, 7'h50, 8'h00);
        req_valid[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk_eq("to_no_resp_while_hung", resp_cnt, rc0);
        chk_eq("to_enable_low", m_enable, 1'b0);
        stuck = 1'b0;
        wait_resp("to", d, e, r);
        chk_eq("to_done", d, 2'b01);
        chk_eq("to_err", e, 2'b01);
        chk_eq("to_rdata_kept", r, 8'h3C);

        // Short stall below the limit, NACKed read returns 0xFF with no error
        stuck = 1'b1;
        set_req(0, 2'b01, 7'h50, 8'h00);
        req_valid[0] = 1'b1;
        repeat (8) @(negedge clk);
        stuck = 1'b0;
        wait_resp("nack", d, e, r);
        chk_eq("nack_done", d, 2'b01);
        chk_eq("nack_err", e, 2'b00);
        chk_eq("nack_rdata", r, 8'hFF);

        // Contention from reset
        do_reset();
        base = t_n;
        set_req(0, 2'b00, 7'h20, 8'h11);
        set_req(1, 2'b00, 7'h21, 8'h22);
        req_valid = 2'b11;
        wait_resp("ct1", d, e, r);
        chk_eq("ct1_done", d, 2'b01);
        @(negedge clk);
        set_req(0, 2'b00, 7'h23, 8'h33);
        req_valid[0] = 1'b1;
        wait_resp("ct2", d, e, r);
        chk_eq("ct2_done", d, 2'b10);
        wait_resp("ct3", d, e, r);
        chk_eq("ct3_done", d, 2'b01);
        chk_eq("ct_order0", t_addr[base], 7'h20);
        chk_eq("ct_order1", t_addr[base+1], 7'h21);
        chk_eq("ct_order2", t_addr[base+2], 7'h23);

        // Reset during WAIT_DONE
        rc0 = resp_cnt;
        stuck = 1'b1;
        set_req(0, 2'b00, 7'h40, 8'hC3);
        req_valid[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk_eq("mid_enable_dropped", m_enable, 1'b0);
        chk_eq("mid_addr_driven", m_addr, 7'h40);
        #2 rst = 1'b1;
        #1;
        chk_eq("mrst_m_addr", m_addr, 7'h00);
        chk_eq("mrst_m_data_in", m_data_in, 8'h00);
        chk_eq("mrst_misc", {resp_done, resp_err, resp_rdata, m_rw, m_enable}, 32'd0);
        req_valid = 2'b00;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("mrst_no_pulse", resp_cnt, rc0);
        set_req(0, 2'b00, 7'h41, 8'h5A);
        req_valid[0] = 1'b1;
        wait_resp("post", d, e, r);
        chk_eq("post_done", d, 2'b01);
        chk_eq("post_err", e, 2'b00);
        chk_eq("post_addr", t_addr[t_n-1], 7'h41);
        chk_eq("post_data", t_data[t_n-1], 8'h5A);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
